mem_bus_responder: RTL
======================

Name: mem_bus_responder

Overview:
- Memory-side responder for the accumulator CPU's memory bus: `addr`, bidirectional `data`, `cs_input`, `we`, `oe`.
- Plays the RAM's role, but adds a programmable wait-state latency, a one-cycle `ready` completion strobe, out-of-range fault reporting and a transaction counter.
- Lets the CPU control unit be developed and verified against a non-zero-latency memory.
- Sits between the control unit (MAR / MBR / `we` / `oe` / `cs`) and backing word storage.

Parameters:
- ADDR_WIDTH, 28, width of `addr` (matches MAR).
- DATA_WIDTH, 32, width of the data word.
- DEPTH_LOG2, 10, log2 of the number of storage words; valid addresses are 0 .. 2**DEPTH_LOG2-1.
- LATENCY, 2, wait cycles inserted before completion; legal range 0..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- addr  input  ADDR_WIDTH  word address from MAR.
- data  inout  DATA_WIDTH  bidirectional bus: write data in, read data out (tri-stated otherwise).
- cs_input  input  1  chip select; a request is present when high.
- we  input  1  1 = write transaction, 0 = read.
- oe  input  1  output enable; gates the read-data drive.
- ready  output  1  one-cycle pulse marking transaction completion.
- fault  output  1  one-cycle pulse, coincident with `ready`, when the latched address is out of range.
- access_count  output  16  completed transactions, wrapping.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; ready=0; fault=0; access_count=0; read-data register=0; rdata_valid=0.
  - Storage contents are not cleared.
  - A pending transaction, including its write, is discarded.
  - `rst` has priority over all other inputs.
- States: IDLE, WAIT, DONE.
- Accept:
  - In IDLE or DONE, `cs_input`=1 at an edge accepts a request.
  - Latched at that edge: `addr`, `we`, `data` (write data), and range check (addr >= 2**DEPTH_LOG2 -> out of range).
  - Wait counter loads LATENCY; next state is WAIT; rdata_valid clears.
- WAIT:
  - Each edge with counter != 0 decrements it.
  - At the edge where counter == 0, go to DONE.
  - Input changes during WAIT are ignored: `cs_input` drop, `addr` or `we` change.
- Completion (the edge entering DONE):
  - Write, in range: storage[addr] <= latched data.
  - Write, out of range: storage unchanged.
  - Read, in range: read-data register <= storage[addr]; rdata_valid=1.
  - Read, out of range: read-data register <= all ones; rdata_valid=1.
  - ready=1 for the DONE cycle; fault=1 only if out of range.
  - access_count increments, wrapping 0xFFFF -> 0x0000.
- Latency: a request accepted at edge N raises `ready` after edge N+1+LATENCY, and `ready` falls after edge N+2+LATENCY.
- DONE exit:
  - At the next edge, `cs_input`=1 accepts a new request (back-to-back); otherwise go to IDLE.
  - Maximum throughput is one transaction per LATENCY+2 cycles.
  - With `cs_input` held high continuously, the responder re-issues transactions on the current `addr`/`we`.
- Bus drive:
  - `data` is driven with the read-data register only when rdata_valid=1 AND `cs_input`=1 AND `oe`=1 AND `we`=0.
  - Otherwise `data` is high-impedance.
  - The drive is combinational on those inputs and persists after DONE until the next accept or reset, so the CPU may sample `data` on any later cycle.
- Read-after-write to the same address in consecutive transactions returns the newly written value.
- `ready` and `fault` are never high outside DONE.

Test Plan:
- Write then read, LATENCY=2:
  - Stimulus: write 0x20000113 to addr 0x100 accepted at edge 0; then read 0x100 with oe=1.
  - Required: ready high only after edge 3 for the write; ready after edge 3 of the read; data=0x20000113; fault=0; access_count=2.
- LATENCY=0 back-to-back with cs held high: ready pulses every 2 cycles; access_count increments once per pulse.
- Out-of-range, DEPTH_LOG2=10:
  - Write 0xDEADBEEF to 0x400: ready and fault pulse together; storage[0x000] is unchanged.
  - Read 0x400: data=0xFFFFFFFF; fault=1.
- Bus release:
  - After a completed read with oe=0: data=Z.
  - With we=1 and oe=1: data=Z, bench-driven value visible.
  - After rst: data=Z.
- Reset mid-WAIT:
  - Write 0x5 to 0x111 (previously holding 0x0); assert rst one cycle after accept.
  - Required: no ready pulse; access_count=0; a later read of 0x111 returns 0x0.
- Mid-transaction input change and counter wrap:
  - Change addr during WAIT: completion uses the latched addr.
  - Preload 0xFFFF completions (or force the counter): the next completion gives access_count=0x0000.

Source files
------------

// File: rtl/mem_bus_responder.sv
// Memory-side bus responder with programmable wait states.
// Adds a ready strobe, out-of-range fault reporting and a completion counter.
module mem_bus_responder #(
    parameter int unsigned ADDR_WIDTH = 28,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    inout  wire  [DATA_WIDTH-1:0] data,
    input  logic                  cs_input,
    input  logic                  we,
    input  logic                  oe,
    output logic                  ready,
    output logic                  fault,
    output logic [15:0]           access_count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [3:0]            wait_q, wait_d;
    logic [15:0]           count_q, count_d;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic                  we_q;
    logic                  oor_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rvalid_q;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic accept;
    logic complete;
    logic addr_oor;
    logic drive;

    assign accept   = cs_input && (state_q != S_WAIT);
    assign complete = (state_q == S_WAIT) && (wait_q == 4'd0);
    // Any set bit above the index field means the word lies past the array.
    assign addr_oor = |addr[ADDR_WIDTH-1:DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (cs_input) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == 4'd0) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = cs_input ? S_WAIT : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        fault = 1'b0;
        if (state_q == S_DONE) begin
            ready = 1'b1;
            fault = oor_q;
        end
    end

    always_comb begin
        wait_d = wait_q;
        if (accept) begin
            wait_d = 4'(LATENCY);
        end else if ((state_q == S_WAIT) && (wait_q != 4'd0)) begin
            wait_d = wait_q - 4'd1;
        end
    end

    always_comb begin
        count_d = count_q;
        if (complete) count_d = count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q   <= 4'd0;
            count_q  <= 16'd0;
            idx_q    <= '0;
            we_q     <= 1'b0;
            oor_q    <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            wait_q  <= wait_d;
            count_q <= count_d;
            if (accept) begin
                idx_q    <= addr[DEPTH_LOG2-1:0];
                we_q     <= we;
                oor_q    <= addr_oor;
                wdata_q  <= data;
                rvalid_q <= 1'b0;
            end
            if (complete && !we_q) begin
                rdata_q  <= oor_q ? '1 : mem_q[idx_q];
                rvalid_q <= 1'b1;
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!rst && complete && we_q && !oor_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign drive        = rvalid_q && cs_input && oe && !we;
    assign data         = drive ? rdata_q : 'z;
    assign access_count = count_q;

endmodule
